// File: rtl/bythoven_pkg.sv
// Shared SRAM constants, default write timing and the program-loader state encoding.
package bythoven_pkg;

    localparam int unsigned SRAM_ADDR_W       = 18;
    localparam int unsigned SRAM_DATA_W       = 16;
    localparam int unsigned SRAM_SETUP_CYCLES = 1;
    localparam int unsigned SRAM_WE_CYCLES    = 3;

    typedef enum logic [2:0] {
        StIdle,
        StByteLo,
        StByteHi,
        StSetup,
        StPulse,
        StHold,
        StFinish
    } loader_state_e;

    // Bits needed for a down-counter that starts at max(a, b) - 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sram_program_loader_if.sv
// Byte-stream, control/status and SRAM pin bundle of the program loader.
// The checksum signal exists only when LOADER_CHECKSUM_EN is defined.
interface sram_program_loader_if import bythoven_pkg::*; #(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) ();

    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              sram_WE;
    logic              sram_CE;
    logic              sram_OE;
    logic              sram_LB;
    logic              sram_UB;
    logic [ADDR_W-1:0] SRAM_A;
    logic [DATA_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] words_written;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    // Host / stream source side.
    modport master (
        output start, base_addr, word_count, in_data, in_valid,
        input  in_ready, sram_WE, sram_CE, sram_OE, sram_LB, sram_UB, SRAM_A,
        input  sram_dq_out, sram_dq_oe, busy, done, words_written
`ifdef LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    // Loader side.
    modport slave (
        input  start, base_addr, word_count, in_data, in_valid,
        output in_ready, sram_WE, sram_CE, sram_OE, sram_LB, sram_UB, SRAM_A,
        output sram_dq_out, sram_dq_oe, busy, done, words_written
`ifdef LOADER_CHECKSUM_EN
        , output checksum
`endif
    );

endinterface

// File: rtl/sram_write_phy.sv
// Async SRAM write timing engine: latches addr/data on req, holds them for SETUP_CYCLES
// with WE high, drops WE for WE_CYCLES, then one HOLD cycle during which ack is high.
module sram_write_phy import bythoven_pkg::*; #(
    parameter int unsigned ADDR_W       = SRAM_ADDR_W,
    parameter int unsigned DATA_W       = SRAM_DATA_W,
    parameter int unsigned SETUP_CYCLES = SRAM_SETUP_CYCLES,
    parameter int unsigned WE_CYCLES    = SRAM_WE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              ack,
    output logic              we_n,
    output logic              dq_oe,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data
);

    localparam int unsigned CNT_W = cnt_width(SETUP_CYCLES, WE_CYCLES);

    loader_state_e     state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_n_q;
    logic              oe_q;
    logic              ack_q;

    // Write-cycle sequencer; every pin is a flop so nothing glitches onto the SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addr;
                        data_q  <= data;
                        oe_q    <= 1'b1;
                        we_n_q  <= 1'b1;
                        cnt_q   <= CNT_W'(SETUP_CYCLES - 1);
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt_q == '0) begin
                        we_n_q  <= 1'b0;
                        cnt_q   <= CNT_W'(WE_CYCLES - 1);
                        state_q <= StPulse;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StPulse: begin
                    if (cnt_q == '0) begin
                        we_n_q  <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StHold: begin
                    oe_q    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack       = ack_q;
    assign we_n      = we_n_q;
    assign dq_oe     = oe_q;
    assign sram_addr = addr_q;
    assign sram_data = data_q;

endmodule

// File: rtl/sram_program_loader.sv
// Program SRAM loader: packs a little-endian byte stream into 16-bit words and writes them
// to consecutive SRAM addresses from base_addr, holding busy until the load completes.
// Optional: define LOADER_CHECKSUM_EN to add a 16-bit running sum of committed words.
module sram_program_loader import bythoven_pkg::*; #(
    parameter int unsigned ADDR_W       = SRAM_ADDR_W,
    parameter int unsigned DATA_W       = SRAM_DATA_W,
    parameter int unsigned SETUP_CYCLES = SRAM_SETUP_CYCLES,
    parameter int unsigned WE_CYCLES    = SRAM_WE_CYCLES
) (
    input logic                  clk,
    input logic                  rst_n,
    sram_program_loader_if.slave bus
);

    loader_state_e     state_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [ADDR_W-1:0] words_q;
    logic [7:0]        lo_q;

    logic              phy_req;
    logic              phy_ack;
    logic              phy_we_n;
    logic              phy_oe;
    logic [ADDR_W-1:0] phy_addr;
    logic [DATA_W-1:0] phy_data;
    logic [DATA_W-1:0] phy_dq;

`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       checksum_q;
`endif

    // The high-byte handshake launches the write with the word assembled on the fly.
    assign phy_req  = (state_q == StByteHi) && bus.in_valid;
    assign phy_data = {bus.in_data, lo_q};

    sram_write_phy #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .SETUP_CYCLES (SETUP_CYCLES),
        .WE_CYCLES    (WE_CYCLES)
    ) u_phy (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (phy_req),
        .addr      (addr_q),
        .data      (phy_data),
        .ack       (phy_ack),
        .we_n      (phy_we_n),
        .dq_oe     (phy_oe),
        .sram_addr (phy_addr),
        .sram_data (phy_dq)
    );

    // Load sequencer: byte packing, address/count bookkeeping and status flags.
    // StSetup here means "word handed to the phy, waiting for its HOLD-cycle ack".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            words_q     <= '0;
            lo_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        addr_q      <= bus.base_addr;
                        remaining_q <= bus.word_count;
                        words_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum_q  <= '0;
`endif
                        if (bus.word_count == '0) begin
                            state_q <= StFinish;
                        end else begin
                            state_q    <= StByteLo;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StByteLo: begin
                    if (bus.in_valid) begin
                        lo_q    <= bus.in_data;
                        state_q <= StByteHi;
                    end
                end
                StByteHi: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        state_q    <= StSetup;
                    end
                end
                StSetup: begin
                    if (phy_ack) begin
                        addr_q      <= addr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        words_q     <= words_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum_q  <= checksum_q + phy_dq[15:0];
`endif
                        if (remaining_q == ADDR_W'(1)) begin
                            busy_q  <= 1'b0;
                            state_q <= StFinish;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= StByteLo;
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // SRAM stays selected with OE high for the whole load, so it never drives DQ.
    assign bus.in_ready      = in_ready_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.words_written = words_q;
    assign bus.sram_CE       = !busy_q;
    assign bus.sram_LB       = !busy_q;
    assign bus.sram_UB       = !busy_q;
    assign bus.sram_OE       = 1'b1;
    assign bus.sram_WE       = phy_we_n;
    assign bus.sram_dq_oe    = phy_oe;
    assign bus.SRAM_A        = phy_addr;
    assign bus.sram_dq_out   = phy_dq;
`ifdef LOADER_CHECKSUM_EN
    assign bus.checksum      = checksum_q;
`endif

endmodule

// File: tb/tb_sram_program_loader.sv
// Self-checking bench for sram_program_loader: directed corner cases plus randomized loads
// compared against a list of expected (address, word) writes built from the byte stream.
module tb_sram_program_loader;

    localparam int WE_CYC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sram_program_loader_if bus ();

    sram_program_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor: records every WE-low pulse and flags pin-level rule violations.
    logic [17:0] wr_a[$];
    logic [15:0] wr_d[$];
    int          wr_len[$];
    int          timing_err, bus_err, done_cnt, busy_cycles;
    logic        mon_in;
    int          mon_len;
    logic [17:0] mon_a, prev_a;
    logic [15:0] mon_d, prev_d;
    logic        prev_oe, prev_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_in  = 1'b0;
            prev_we = 1'b1;
            prev_oe = 1'b0;
        end else begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.sram_OE !== 1'b1) bus_err++;
            if (bus.busy === 1'b1 &&
                (bus.sram_CE !== 1'b0 || bus.sram_LB !== 1'b0 || bus.sram_UB !== 1'b0))
                bus_err++;
            if (bus.busy === 1'b0 && (bus.sram_CE !== 1'b1 || bus.sram_dq_oe !== 1'b0))
                bus_err++;
            if (bus.sram_WE === 1'b0) begin
                if (!mon_in) begin
                    mon_in  = 1'b1;
                    mon_len = 0;
                    mon_a   = bus.SRAM_A;
                    mon_d   = bus.sram_dq_out;
                    if (!(prev_we === 1'b1 && prev_oe === 1'b1 && prev_a === bus.SRAM_A &&
                          prev_d === bus.sram_dq_out))
                        timing_err++;
                end
                if (bus.SRAM_A !== mon_a || bus.sram_dq_out !== mon_d || bus.sram_dq_oe !== 1'b1)
                    timing_err++;
                mon_len++;
            end else if (mon_in) begin
                // First cycle after the pulse is the hold cycle.
                mon_in = 1'b0;
                if (bus.sram_dq_oe !== 1'b1 || bus.SRAM_A !== mon_a || bus.sram_dq_out !== mon_d)
                    timing_err++;
                wr_a.push_back(mon_a);
                wr_d.push_back(mon_d);
                wr_len.push_back(mon_len);
            end
            prev_we = bus.sram_WE;
            prev_oe = bus.sram_dq_oe;
            prev_a  = bus.SRAM_A;
            prev_d  = bus.sram_dq_out;
        end
    end

    logic [7:0] stim[$];

    task automatic clear_mon();
        wr_a.delete();
        wr_d.delete();
        wr_len.delete();
        timing_err  = 0;
        bus_err     = 0;
        done_cnt    = 0;
        busy_cycles = 0;
    endtask

    task automatic fill_random(input int n);
        stim.delete();
        repeat (n) stim.push_back(8'($urandom));
    endtask

    // All driver tasks start and end at 1 time unit after a rising edge.
    task automatic pulse_start(input logic [17:0] base, input logic [17:0] count);
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = count;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.base_addr  = 18'($urandom);
        bus.word_count = 18'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        logic hs;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 200; k++) begin
            hs = bus.in_ready;
            @(posedge clk); #1;
            if (hs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic do_load(input logic [17:0] base, input int count, input int max_gap,
                           input bit stall_mid, input string tag);
        int          gap, lat, stall_err, n;
        bit          ok;
        logic [17:0] ea;
        logic [15:0] ed, esum;
        clear_mon();
        stall_err = 0;
        pulse_start(base, 18'(count));
        for (int i = 0; i < 2 * count; i++) begin
            gap = $urandom_range(max_gap, 0);
            repeat (gap) begin @(posedge clk); #1; end
            if (stall_mid && i == 1) begin
                repeat (10) begin
                    if (bus.in_ready !== 1'b1 || bus.sram_WE !== 1'b1 ||
                        bus.sram_dq_oe !== 1'b0)
                        stall_err++;
                    @(posedge clk); #1;
                end
            end
            send_byte(stim[i], ok);
            if (!ok) begin
                check_eq({tag, "_handshake_timeout"}, 32'(0), 32'(1));
                return;
            end
        end
        // A start while the last word is still being written must be ignored.
        if (count > 0) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        lat = 0;
        while (bus.done !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) begin
            check_eq({tag, "_done_timeout"}, 32'(0), 32'(1));
            return;
        end
        if (count == 0) check_eq({tag, "_done_latency"}, 32'(lat), 32'(1));
        check_eq({tag, "_words_at_done"}, 32'(bus.words_written), 32'(count));
        check_eq({tag, "_busy_at_done"}, 32'(bus.busy), 32'(0));
        esum = '0;
        for (int i = 0; i < count; i++) esum = esum + {stim[2*i+1], stim[2*i]};
`ifdef LOADER_CHECKSUM_EN
        check_eq({tag, "_checksum"}, 32'(bus.checksum), 32'(esum));
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_words_held"}, 32'(bus.words_written), 32'(count));
        check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'(1));
        check_eq({tag, "_write_count"}, 32'(wr_a.size()), 32'(count));
        n = (wr_a.size() < count) ? wr_a.size() : count;
        for (int i = 0; i < n; i++) begin
            ea = base + 18'(i);
            ed = {stim[2*i+1], stim[2*i]};
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_a[i]), 32'(ea));
            check_eq($sformatf("%s_data%0d", tag, i), 32'(wr_d[i]), 32'(ed));
            check_eq($sformatf("%s_we_len%0d", tag, i), 32'(wr_len[i]), 32'(WE_CYC));
        end
        check_eq({tag, "_timing"}, 32'(timing_err), 32'(0));
        check_eq({tag, "_bus_rules"}, 32'(bus_err), 32'(0));
        if (stall_mid) check_eq({tag, "_stall"}, 32'(stall_err), 32'(0));
        if (count == 0) check_eq({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          lat;
        logic [17:0] rb;
        int          rc;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_we", 32'(bus.sram_WE), 32'(1));
        check_eq("rst_ce", 32'(bus.sram_CE), 32'(1));
        check_eq("rst_oe", 32'(bus.sram_OE), 32'(1));
        check_eq("rst_lb", 32'(bus.sram_LB), 32'(1));
        check_eq("rst_ub", 32'(bus.sram_UB), 32'(1));
        check_eq("rst_addr", 32'(bus.SRAM_A), 32'(0));
        check_eq("rst_dq", 32'(bus.sram_dq_out), 32'(0));
        check_eq("rst_dq_oe", 32'(bus.sram_dq_oe), 32'(0));
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'(0));
        check_eq("rst_busy", 32'(bus.busy), 32'(0));
        check_eq("rst_done", 32'(bus.done), 32'(0));
        check_eq("rst_words", 32'(bus.words_written), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        stim.delete();
        stim.push_back(8'h34); stim.push_back(8'h12);
        stim.push_back(8'h78); stim.push_back(8'h56);
        do_load(18'h00010, 2, 0, 1'b0, "basic");

        fill_random(2);
        do_load(18'h00100, 1, 0, 1'b1, "stall");

        fill_random(4);
        do_load(18'h3FFFF, 2, 1, 1'b0, "wrap");

        stim.delete();
        do_load(18'h01234, 0, 0, 1'b0, "zero");

        stim.delete();
        stim.push_back(8'hFF); stim.push_back(8'hFF);
        stim.push_back(8'h02); stim.push_back(8'h00);
        do_load(18'h00040, 2, 0, 1'b0, "csum");

        // Reset asserted while WE is low.
        clear_mon();
        fill_random(4);
        pulse_start(18'h00200, 18'd2);
        send_byte(stim[0], ok);
        check_eq("rstmid_hs0", 32'(ok), 32'(1));
        send_byte(stim[1], ok);
        check_eq("rstmid_hs1", 32'(ok), 32'(1));
        lat = 0;
        while (bus.sram_WE !== 1'b0 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("rstmid_we_low_seen", 32'(bus.sram_WE), 32'(0));
        #3 rst_n = 1'b0;
        #1;
        check_eq("rstmid_we", 32'(bus.sram_WE), 32'(1));
        check_eq("rstmid_dq_oe", 32'(bus.sram_dq_oe), 32'(0));
        check_eq("rstmid_busy", 32'(bus.busy), 32'(0));
        check_eq("rstmid_ce", 32'(bus.sram_CE), 32'(1));
        check_eq("rstmid_in_ready", 32'(bus.in_ready), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rstrel_busy", 32'(bus.busy), 32'(0));
        check_eq("rstrel_words", 32'(bus.words_written), 32'(0));
        check_eq("rstrel_in_ready", 32'(bus.in_ready), 32'(0));
        fill_random(6);
        do_load(18'h00300, 3, 2, 1'b0, "after_rst");

        for (int t = 0; t < 8; t++) begin
            rc = $urandom_range(5, 1);
            if (t % 2 == 1) rb = 18'h3FFFF - 18'($urandom_range(3, 0));
            else rb = 18'($urandom);
            fill_random(2 * rc);
            do_load(rb, rc, 3, 1'b0, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
